// File: rtl/i_deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package i_deserializer_pkg;

    typedef enum logic {
        WAIT_LOCK,
        RUN
    } state_e;

    localparam int unsigned WIDTH_MIN = 3;
    localparam int unsigned WIDTH_MAX = 10;
    localparam int unsigned CNT_W     = 4;

    // True when the deserialization ratio is supported.
    function automatic logic width_ok(input int unsigned width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/i_deserializer_if.sv
// Serial input / parallel output bundle of the deserializer.
// master: the serial source side; slave: the deserializer itself.
interface i_deserializer_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             D;
    logic             EN;
    logic             PLL_LOCK;
    logic             BITSLIP_ADJ;
    logic [WIDTH-1:0] Q;
    logic             DATA_VALID;
    logic             BITSLIP_BUSY;

    modport master (
        output D, EN, PLL_LOCK, BITSLIP_ADJ,
        input  Q, DATA_VALID, BITSLIP_BUSY
    );

    modport slave (
        input  D, EN, PLL_LOCK, BITSLIP_ADJ,
        output Q, DATA_VALID, BITSLIP_BUSY
    );

endinterface

// File: rtl/i_deserializer_slip_ctrl.sv
// Bit counter and bitslip bookkeeping: decides when a word completes and
// when a captured bit is swallowed to move the word boundary one bit later.
module i_deserializer_slip_ctrl
    import i_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_lock,
    input  logic i_en,
    input  logic i_bitslip_adj,
    output logic o_word_done,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    logic             r_adj_q;
    logic             r_pending;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pending_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_adj_rise;
    logic             w_capture;
    logic             w_drop;

    assign w_adj_rise = i_bitslip_adj & ~r_adj_q;
    assign w_capture  = i_run & i_lock & i_en;
    assign w_drop     = i_run & ~i_lock;

    // A slip-consuming edge never completes a word.
    assign o_word_done = w_capture & ~r_pending & (r_cnt == CntLast);
    assign o_busy      = r_pending;

    // Next counter / slip state; lock loss clears everything and beats a slip.
    always_comb begin
        w_pending_next = r_pending;
        w_cnt_next     = r_cnt;
        if (w_drop) begin
            w_pending_next = 1'b0;
            w_cnt_next     = '0;
        end else if (i_run) begin
            if (w_capture) begin
                if (r_pending) begin
                    w_pending_next = 1'b0;
                end else if (r_cnt == CntLast) begin
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            // Requests arriving while a slip is pending are dropped, not queued.
            if (w_adj_rise && !r_pending) begin
                w_pending_next = 1'b1;
            end
        end
    end

    // Edge-detect copy, slip flag and bit counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_adj_q   <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_adj_q   <= i_bitslip_adj;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
        end
    end

endmodule

// File: rtl/i_deserializer.sv
// Serial-to-parallel receiver, MSB first, gated on PLL lock, with bitslip.
module i_deserializer
    import i_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              CLK_IN,
    input  logic              RST,
    i_deserializer_if.slave   bus
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("i_deserializer: WIDTH must be within 3..10");
    end

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_run;
    logic             w_capture;
    logic             w_word_done;
    logic             w_busy;

    assign w_run        = (r_state == RUN);
    assign w_capture    = w_run & bus.PLL_LOCK & bus.EN;
    assign w_shift_next = {r_shift[WIDTH-2:0], bus.D};

    i_deserializer_slip_ctrl #(
        .WIDTH (WIDTH)
    ) u_slip_ctrl (
        .i_clk         (CLK_IN),
        .i_rst_n       (RST),
        .i_run         (w_run),
        .i_lock        (bus.PLL_LOCK),
        .i_en          (bus.EN),
        .i_bitslip_adj (bus.BITSLIP_ADJ),
        .o_word_done   (w_word_done),
        .o_busy        (w_busy)
    );

    // Lock FSM next state: enter RUN when lock is seen, leave as soon as it drops.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_LOCK: if (bus.PLL_LOCK)  w_state_next = RUN;
            RUN:       if (!bus.PLL_LOCK) w_state_next = WAIT_LOCK;
            default:   w_state_next = WAIT_LOCK;
        endcase
    end

    // State, shift register, output word and valid strobe.
    always_ff @(posedge CLK_IN) begin
        if (!RST) begin
            r_state <= WAIT_LOCK;
            r_shift <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_shift <= w_shift_next;
            end
            if (w_word_done) begin
                r_q <= w_shift_next;
            end
            r_valid <= w_word_done;
        end
    end

    assign bus.Q            = r_q;
    assign bus.DATA_VALID   = r_valid;
    assign bus.BITSLIP_BUSY = w_busy;

endmodule
